btb_assoc: RTL and testbench
============================

# btb_assoc

Parametrised set-associative branch target buffer for the fetch stage, succeeding the direct-mapped BTB. Fetch presents `EIP_fetch` each cycle and receives the predicted `EIP_target`, even/odd fetch-line pointers and a taken prediction in the same cycle. Writeback trains the buffer with resolved branches using per-entry 2-bit saturating counters and per-set LRU replacement.

## Interface
- `ADDR_W`, 32, width of EIP/FIP/target addresses
- `SETS`, 8, number of sets; power of two, ≥2
- `WAYS`, 2, associativity; power of two, 1..8
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high; clears all state
- `flush` in 1: synchronous invalidate of all entries, same effect as `reset`
- `EIP_fetch` in ADDR_W: lookup address
- `LD` in 1: writeback update strobe
- `taken_WB` in 1: resolved direction of branch at `EIP_WB`
- `EIP_WB` in ADDR_W: branch address being trained
- `target_WB`, `FIP_E_WB`, `FIP_O_WB` in ADDR_W: resolved target and its even/odd fetch-line pointers
- `EIP_target`, `FIP_E_target`, `FIP_O_target` out ADDR_W: stored target/pointers of hitting way; 0 on miss
- `miss_hit` out 1: 1 = valid tag match in indexed set
- `pred_taken` out 1: `miss_hit` AND counter MSB of hitting way

## Operation
- Index = `EIP[log2(SETS)-1:0]`; tag = `EIP[ADDR_W-1:log2(SETS)]`; full tag compare, no aliasing.
- Entry: valid, tag, target, FIP_E, FIP_O, 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Lookup: combinational from registered array; at most one way matches (allocation never duplicates a tag).
- Update (`LD`=1, no flush/reset):
  - hit in set of `EIP_WB`: overwrite target/FIP_E/FIP_O; counter +1 if `taken_WB`, −1 otherwise, saturating at 11/00; hitting way becomes MRU.
  - miss and `taken_WB`=1: allocate lowest-numbered invalid way, else LRU way; counter = 10; way becomes MRU.
  - miss and `taken_WB`=0: no change.
- LRU: per-set age ordering of WAYS entries (WAYS=1: trivial). Lookups do not touch LRU; only updates do.
- `reset` or `flush`: all valid=0, counters=00, LRU order reset to way0 oldest … wayN-1 newest. Either wins over simultaneous `LD`.

## Timing
- Lookup latency 0 cycles (combinational output from state).
- Update visible to lookups the cycle after the `LD` edge (unless bypass enabled, below).
- Reset values: all outputs 0 (no valid entries, hence `miss_hit`=0, `pred_taken`=0, targets 0) from the cycle after `reset` sampled high.
- Reset/flush mid-training: the pending `LD` in that cycle is dropped.
- Counter arithmetic 2-bit saturating; no wrap 11→00 or 00→11.

## Configuration
- `BTB_BYPASS_EN` defined: when `LD`=1 and `EIP_WB`==`EIP_fetch` in the same cycle (and no reset/flush), outputs reflect the post-update entry (new target/pointers, new counter; `miss_hit`=1 only if the update hits or allocates).
- Undefined: same-cycle lookup sees pre-update state.

## Structure
- Package `btb_pkg`: counter encodings (`CTR_SNT`,`CTR_WNT`,`CTR_WT`,`CTR_ST`), allocation init value, entry struct typedef, index/tag width functions.
- Sub-module `btb_lru_ctrl`: per-set LRU state, takes touch-way + enable, returns victim way; instantiated once with SETS×WAYS state.

## Test plan
- Reset then lookup `EIP_fetch`=32'h12345678 -> `miss_hit`=0, `pred_taken`=0, all targets 0.
- `LD`, taken, `EIP_WB`=32'h12345678, `target_WB`=32'hCCCCCCCC, FIP_E/O=32'h12345670/71; next cycle lookup same EIP -> hit, `EIP_target`=CCCCCCCC, counter 10, `pred_taken`=1.
- Two not-taken updates to that entry -> counter 10→01→00, `pred_taken`=0, `miss_hit`=1; third not-taken stays 00.
- WAYS=2: allocate 32'h00000010, 32'h00000020, 32'h00000030 (all index 0) taken -> 0x10 evicted; then update 0x20 and allocate 0x40 -> 0x30 evicted.
- `flush` with `LD` same cycle -> all misses next cycle, the `LD` entry absent.
- With `BTB_BYPASS_EN`: `LD` of 32'h22224444 taken while `EIP_fetch`=32'h22224444 -> same-cycle hit, target 32'h76543210; without macro -> miss that cycle, hit next.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative branch target buffer:
// counter encodings, the per-entry state struct and the width helpers.
package btb_pkg;

  // 2-bit direction counter encodings
  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  // A freshly allocated entry starts weakly taken
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  // Per-entry control state; tag and payload arrays live beside it
  typedef struct packed {
    logic       valid;
    logic [1:0] ctr;
  } btb_meta_t;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - $clog2(sets);
  endfunction

  // At least one bit so a direct-mapped build still has a legal way select
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Saturating counter step: never wraps 11->00 or 00->11
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_lru_ctrl.sv
// Per-set LRU age ordering. Each way of each set holds a rank:
// 0 = least recently used, WAYS-1 = most recently used. A touch promotes
// the way to MRU and shifts every younger way one step toward LRU.
// The victim is the rank-0 way of the selected set.
module btb_lru_ctrl
  import btb_pkg::*;
#(
  parameter int SETS = 8,
  parameter int WAYS = 2,
  parameter int IW   = idx_w(SETS),
  parameter int WW   = way_w(WAYS)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic [IW-1:0] set_sel,
  input  logic [WW-1:0] touch_way,
  input  logic          touch_en,
  output logic [WW-1:0] victim_way
);

  logic [WW-1:0] age_q [SETS][WAYS];

  // Victim = way holding rank 0 in the selected set
  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[set_sel][w] == '0) victim_way = WW'(w);
    end
  end

  // Rank update: clear restores way0 oldest .. wayN-1 newest
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WW'(w);
      end
    end else if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WW'(w) == touch_way)
          age_q[set_sel][w] <= WW'(WAYS - 1);
        else if (age_q[set_sel][w] > age_q[set_sel][touch_way])
          age_q[set_sel][w] <= age_q[set_sel][w] - WW'(1);
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer. Fetch lookup is combinational from
// the registered entries; writeback trains 2-bit counters and allocates on
// taken misses (lowest invalid way, else the set's LRU way).
// Optional macro BTB_BYPASS_EN: a same-cycle writeback to the fetched
// address is forwarded to the lookup outputs.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int SETS   = 8,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] EIP_fetch,
  input  logic              LD,
  input  logic              taken_WB,
  input  logic [ADDR_W-1:0] EIP_WB,
  input  logic [ADDR_W-1:0] target_WB,
  input  logic [ADDR_W-1:0] FIP_E_WB,
  input  logic [ADDR_W-1:0] FIP_O_WB,
  output logic [ADDR_W-1:0] EIP_target,
  output logic [ADDR_W-1:0] FIP_E_target,
  output logic [ADDR_W-1:0] FIP_O_target,
  output logic              miss_hit,
  output logic              pred_taken
);

  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(ADDR_W, SETS);
  localparam int WW = way_w(WAYS);

  btb_meta_t         meta_q [SETS][WAYS];
  logic [TW-1:0]     tag_q  [SETS][WAYS];
  logic [ADDR_W-1:0] tgt_q  [SETS][WAYS];
  logic [ADDR_W-1:0] fe_q   [SETS][WAYS];
  logic [ADDR_W-1:0] fo_q   [SETS][WAYS];

  logic          clr;
  logic [IW-1:0] f_idx, u_idx;
  logic [TW-1:0] f_tag, u_tag;
  logic          f_hit, u_hit, u_free;
  logic [WW-1:0] f_way, u_way, u_free_way, alloc_way, victim_way, wr_way;
  logic [1:0]    u_ctr, new_ctr;
  logic          do_write;

  assign clr   = reset | flush;
  assign f_idx = EIP_fetch[IW-1:0];
  assign f_tag = EIP_fetch[ADDR_W-1:IW];
  assign u_idx = EIP_WB[IW-1:0];
  assign u_tag = EIP_WB[ADDR_W-1:IW];

  // Fetch-side tag match; allocation never duplicates a tag so at most one way hits
  always_comb begin
    f_hit = 1'b0;
    f_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (meta_q[f_idx][w].valid && tag_q[f_idx][w] == f_tag) begin
        f_hit = 1'b1;
        f_way = WW'(w);
      end
    end
  end

  // Writeback-side tag match and allocation choice (lowest invalid way wins)
  always_comb begin
    u_hit      = 1'b0;
    u_way      = '0;
    u_ctr      = CTR_SNT;
    u_free     = 1'b0;
    u_free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (meta_q[u_idx][w].valid && tag_q[u_idx][w] == u_tag) begin
        u_hit = 1'b1;
        u_way = WW'(w);
        u_ctr = meta_q[u_idx][w].ctr;
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!meta_q[u_idx][w].valid) begin
        u_free     = 1'b1;
        u_free_way = WW'(w);
      end
    end
    alloc_way = u_free ? u_free_way : victim_way;
  end

  // A write happens on a hit, or on a taken miss; reset/flush drops the update
  assign do_write = LD & ~clr & (u_hit | taken_WB);
  assign wr_way   = u_hit ? u_way : alloc_way;
  assign new_ctr  = u_hit ? ctr_next(u_ctr, taken_WB) : CTR_ALLOC;

  btb_lru_ctrl #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk        (clk),
    .clear      (clr),
    .set_sel    (u_idx),
    .touch_way  (wr_way),
    .touch_en   (do_write),
    .victim_way (victim_way)
  );

  // Entry storage: clear invalidates everything, otherwise apply the training write
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          meta_q[s][w] <= '0;
          tag_q[s][w]  <= '0;
          tgt_q[s][w]  <= '0;
          fe_q[s][w]   <= '0;
          fo_q[s][w]   <= '0;
        end
      end
    end else if (do_write) begin
      meta_q[u_idx][wr_way].valid <= 1'b1;
      meta_q[u_idx][wr_way].ctr   <= new_ctr;
      tag_q[u_idx][wr_way]        <= u_tag;
      tgt_q[u_idx][wr_way]        <= target_WB;
      fe_q[u_idx][wr_way]         <= FIP_E_WB;
      fo_q[u_idx][wr_way]         <= FIP_O_WB;
    end
  end

  // Prediction outputs: hitting way's payload, zeros on miss
  always_comb begin
    miss_hit     = f_hit;
    EIP_target   = f_hit ? tgt_q[f_idx][f_way] : '0;
    FIP_E_target = f_hit ? fe_q[f_idx][f_way]  : '0;
    FIP_O_target = f_hit ? fo_q[f_idx][f_way]  : '0;
    pred_taken   = f_hit & meta_q[f_idx][f_way].ctr[1];
`ifdef BTB_BYPASS_EN
    if (do_write && EIP_WB == EIP_fetch) begin
      miss_hit     = 1'b1;
      EIP_target   = target_WB;
      FIP_E_target = FIP_E_WB;
      FIP_O_target = FIP_O_WB;
      pred_taken   = new_ctr[1];
    end
`endif
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Testbench for btb_assoc (ADDR_W=32, SETS=8, WAYS=2). The reference model
// is a recency-ordered list of trained branches; eviction removes the least
// recently trained entry of a full set.
module tb_btb_assoc;

  localparam int AW   = 32;
  localparam int SETS = 8;
  localparam int WAYS = 2;

  logic          clk, reset, flush, LD, taken_WB;
  logic [AW-1:0] EIP_fetch, EIP_WB, target_WB, FIP_E_WB, FIP_O_WB;
  logic [AW-1:0] EIP_target, FIP_E_target, FIP_O_target;
  logic          miss_hit, pred_taken;

  int n_cmp = 0;
  int n_err = 0;

  btb_assoc #(.ADDR_W(AW), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .EIP_fetch    (EIP_fetch),
    .LD           (LD),
    .taken_WB     (taken_WB),
    .EIP_WB       (EIP_WB),
    .target_WB    (target_WB),
    .FIP_E_WB     (FIP_E_WB),
    .FIP_O_WB     (FIP_O_WB),
    .EIP_target   (EIP_target),
    .FIP_E_target (FIP_E_target),
    .FIP_O_target (FIP_O_target),
    .miss_hit     (miss_hit),
    .pred_taken   (pred_taken)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout, need summary");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] eip;
    logic [31:0] tgt;
    logic [31:0] fe;
    logic [31:0] fo;
    int          ctr;
    longint      stamp;
  } ent_t;

  ent_t   mdl[$];
  longint now = 0;

  function automatic int find(input logic [31:0] eip);
    foreach (mdl[i]) if (mdl[i].eip == eip) return i;
    return -1;
  endfunction

  function automatic void model_update(input logic tk, input logic [31:0] wb,
                                       input logic [31:0] tg, input logic [31:0] fe,
                                       input logic [31:0] fo);
    int   i;
    int   cnt;
    int   old;
    ent_t e;
    now++;
    i = find(wb);
    if (i >= 0) begin
      mdl[i].tgt   = tg;
      mdl[i].fe    = fe;
      mdl[i].fo    = fo;
      if (tk) mdl[i].ctr = (mdl[i].ctr == 3) ? 3 : mdl[i].ctr + 1;
      else    mdl[i].ctr = (mdl[i].ctr == 0) ? 0 : mdl[i].ctr - 1;
      mdl[i].stamp = now;
    end else if (tk) begin
      cnt = 0;
      old = -1;
      foreach (mdl[j]) begin
        if ((mdl[j].eip % SETS) == (wb % SETS)) begin
          cnt++;
          if (old < 0 || mdl[j].stamp < mdl[old].stamp) old = j;
        end
      end
      if (cnt >= WAYS) mdl.delete(old);
      e.eip = wb; e.tgt = tg; e.fe = fe; e.fo = fo; e.ctr = 2; e.stamp = now;
      mdl.push_back(e);
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check the lookup, then let the edge commit
  task automatic step(input logic rst, input logic fl, input logic ld, input logic tk,
                      input logic [31:0] wb, input logic [31:0] tg, input logic [31:0] fe,
                      input logic [31:0] fo, input logic [31:0] fetch, input string tag);
    int          i;
    logic        e_hit, e_pt;
    logic [31:0] e_t, e_fe, e_fo;
    ent_t        saved[$];
    longint      saved_now;
    @(negedge clk);
    reset = rst; flush = fl; LD = ld; taken_WB = tk;
    EIP_WB = wb; target_WB = tg; FIP_E_WB = fe; FIP_O_WB = fo; EIP_fetch = fetch;
    saved = mdl;
    saved_now = now;
`ifdef BTB_BYPASS_EN
    if (ld && !rst && !fl && wb == fetch) model_update(tk, wb, tg, fe, fo);
`endif
    i = find(fetch);
    e_hit = 1'b0; e_pt = 1'b0; e_t = '0; e_fe = '0; e_fo = '0;
    if (i >= 0) begin
      e_hit = 1'b1;
      e_pt  = (mdl[i].ctr >= 2);
      e_t   = mdl[i].tgt;
      e_fe  = mdl[i].fe;
      e_fo  = mdl[i].fo;
    end
    mdl = saved;
    now = saved_now;
    #1;
    chk({tag, ".miss_hit"},   {31'd0, miss_hit},   {31'd0, e_hit});
    chk({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, e_pt});
    chk({tag, ".EIP_target"}, EIP_target,   e_t);
    chk({tag, ".FIP_E"},      FIP_E_target, e_fe);
    chk({tag, ".FIP_O"},      FIP_O_target, e_fo);
    @(posedge clk);
    if (rst || fl) mdl.delete();
    else if (ld) model_update(tk, wb, tg, fe, fo);
  endtask

  task automatic look(input logic [31:0] fetch, input string tag);
    step(0, 0, 0, 0, '0, '0, '0, '0, fetch, tag);
  endtask

  task automatic train(input logic tk, input logic [31:0] wb, input logic [31:0] tg,
                       input logic [31:0] fetch, input string tag);
    step(0, 0, 1, tk, wb, tg, tg ^ 32'h1, tg ^ 32'h2, fetch, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] wb, fetch;
    logic        rst, fl, ld, tk;
    reset = 1'b1; flush = 1'b0; LD = 1'b0; taken_WB = 1'b0;
    EIP_fetch = '0; EIP_WB = '0; target_WB = '0; FIP_E_WB = '0; FIP_O_WB = '0;
    repeat (2) @(posedge clk);

    // Empty buffer after reset
    look(32'h12345678, "reset_lookup");

    // First allocation, same-cycle lookup then next-cycle hit with counter 10
    step(0, 0, 1, 1, 32'h12345678, 32'hCCCCCCCC, 32'h12345670, 32'h12345671,
         32'h12345678, "alloc_same_cycle");
    look(32'h12345678, "alloc_hit");

    // Not-taken training walks 10 -> 01 -> 00 and saturates
    step(0, 0, 1, 0, 32'h12345678, 32'hCCCCCCCC, 32'h12345670, 32'h12345671, 32'h0, "nt1");
    look(32'h12345678, "ctr_wnt");
    step(0, 0, 1, 0, 32'h12345678, 32'hCCCCCCCC, 32'h12345670, 32'h12345671, 32'h0, "nt2");
    look(32'h12345678, "ctr_snt");
    step(0, 0, 1, 0, 32'h12345678, 32'hCCCCCCCC, 32'h12345670, 32'h12345671, 32'h0, "nt3");
    look(32'h12345678, "ctr_snt_sat");
    step(0, 0, 1, 1, 32'h12345678, 32'hDDDD0000, 32'h12345670, 32'h12345671, 32'h0, "t_back");
    look(32'h12345678, "ctr_wnt_again");

    // LRU eviction in set 0
    step(0, 1, 0, 0, '0, '0, '0, '0, 32'h0, "flush0");
    train(1, 32'h00000010, 32'hA0000010, 32'h0, "alloc10");
    train(1, 32'h00000020, 32'hA0000020, 32'h0, "alloc20");
    train(1, 32'h00000030, 32'hA0000030, 32'h0, "alloc30");
    look(32'h00000010, "evicted10");
    look(32'h00000020, "kept20");
    look(32'h00000030, "kept30");
    train(1, 32'h00000020, 32'hB0000020, 32'h0, "touch20");
    train(1, 32'h00000040, 32'hA0000040, 32'h0, "alloc40");
    look(32'h00000030, "evicted30");
    look(32'h00000020, "kept20b");
    look(32'h00000040, "kept40");
    // Not-taken miss must not allocate
    train(0, 32'h00000050, 32'hA0000050, 32'h0, "nt_miss");
    look(32'h00000050, "nt_miss_absent");

    // Flush beats a simultaneous LD
    step(0, 1, 1, 1, 32'h00000058, 32'hEEEE0000, 32'h1, 32'h2, 32'h00000020, "flush_ld");
    look(32'h00000058, "flush_ld_absent");
    look(32'h00000020, "flush_cleared");

    // Reset beats a simultaneous LD
    train(1, 32'h00000060, 32'hA0000060, 32'h0, "pre_reset");
    step(1, 0, 1, 1, 32'h00000068, 32'hEEEE1111, 32'h1, 32'h2, 32'h00000060, "reset_ld");
    look(32'h00000068, "reset_ld_absent");
    look(32'h00000060, "reset_cleared");

    // Same-cycle training of the fetched address
    step(0, 0, 1, 1, 32'h22224444, 32'h76543210, 32'h22224440, 32'h22224441,
         32'h22224444, "bypass_cycle");
    look(32'h22224444, "bypass_next");

    // Randomized traffic over a small address pool to force conflicts
    for (int n = 0; n < 600; n++) begin
      wb    = ($urandom_range(0, 3) << 20) | $urandom_range(0, 15);
      fetch = ($urandom_range(0, 1) == 1) ? wb
            : (($urandom_range(0, 3) << 20) | $urandom_range(0, 15));
      rst = ($urandom_range(0, 199) == 0);
      fl  = ($urandom_range(0, 79) == 0);
      ld  = ($urandom_range(0, 9) < 7);
      tk  = ($urandom_range(0, 9) < 6);
      step(rst, fl, ld, tk, wb, $urandom, $urandom, $urandom, fetch, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
